store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Post-commit store buffer between the store queue and the data-memory port. Committed stores leave the store queue head in program order and are held here, then written to memory one at a time over a req/ack handshake. Loads probe the buffer each cycle for a word-address match, so store-to-load forwarding still covers stores that are committed but not yet written.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- ADDR_W, `ADDR_LEN, address width
- DATA_W, `DATA_LEN, data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  committed store offered by the store queue
- in_ready  out  1  buffer can accept; equals !full
- in_addr  in  ADDR_W  store address (word stores only)
- in_data  in  DATA_W  store data
- mem_req  out  1  write request to data memory
- mem_addr  out  ADDR_W  head entry address while mem_req, else 0
- mem_wdata  out  DATA_W  head entry data while mem_req, else 0
- mem_ack  in  1  memory accepts the write this cycle; only meaningful while mem_req
- fwd_addr  in  ADDR_W  load probe address
- fwd_hit  out  1  some valid entry matches fwd_addr
- fwd_data  out  DATA_W  data of the youngest matching entry, else 0
- wb_empty  out  1  count == 0
- wb_count  out  log2(DEPTH)+1  occupancy

## Operation
- Circular FIFO with head, tail and count. head and tail are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: when in_valid && in_ready at an edge, write {addr, data} at tail, set valid, advance tail.
- Pop: when mem_req && mem_ack at an edge, clear valid at head, advance head.
- Count: push and pop on the same edge leave count unchanged. in_ready comes from registered count, so a full buffer does not accept even while popping.
- Drain FSM, two states:
  - IDLE: mem_req = 0. Go to SEND at an edge where count != 0 (registered count before that edge).
  - SEND: mem_req = 1. mem_addr and mem_wdata come from the head entry and stay stable until ack.
  - On mem_ack, the head pops. If count after that edge is non-zero, stay in SEND and present the next head on the next cycle. Otherwise go to IDLE.
  - A push on the same edge as the last pop counts as non-zero, so the FSM stays in SEND.
  - Without ack, stay in SEND indefinitely. There is no timeout.
  - mem_ack while in IDLE is ignored.
- Forwarding is combinational over the registered entries:
  - Compare addr[ADDR_W-1:2] against fwd_addr[ADDR_W-1:2] on every valid entry.
  - Priority goes to the entry nearest tail (youngest).
  - The entry currently in SEND is still valid and is included.
  - A store being pushed this cycle is not visible until the next cycle.
- Stores are never flushed; they are architecturally committed.

## Timing
- Reset values: in_ready = 1, mem_req = 0, mem_addr = 0, mem_wdata = 0, fwd_hit = 0, fwd_data = 0, wb_empty = 1, wb_count = 0, state = IDLE, all valid = 0.
- Push at edge E makes the entry visible (wb_count, forwarding) from E+1. mem_req rises at E+1 edge, i.e. visible from after edge E+1. Minimum latency is 2 edges from accept to request.
- Back-to-back drain: with ack held high, one write completes per cycle with no bubble between entries.
- Full: in_ready = 0 while wb_count == DEPTH. It returns to 1 the cycle after a pop.
- Reset asserted mid-operation: at that edge all entries are dropped, the FSM returns to IDLE and mem_req = 0 the next cycle. Any ack in the reset cycle is ignored, and the in-flight write is considered abandoned.
- Outputs depend only on registered state and fwd_addr. There is no combinational path from in_valid or mem_ack to any output.

## Test plan
- Reset then a single store: push addr 0x100, data 0xAAAA_0001 with mem_ack tied high. Required: wb_count = 1 after edge 1; mem_req, with mem_addr 0x100 and mem_wdata 0xAAAA_0001, after edge 2; wb_empty = 1 after edge 3.
- Fill and backpressure: mem_ack = 0 and push 5 stores. Required: 4 accepted; in_ready = 0 with wb_count = 4; the 5th is held. Then a single ack: in_ready = 1 the next cycle and the 5th push succeeds. Check ordering 0x10, 0x14, 0x18, 0x1C, 0x20 at mem_addr.
- Wrap-around: 10 pushes interleaved with acks. Required: memory sees all 10 addresses in push order, count never exceeds 4, and head/tail wrap with no loss.
- Forwarding priority: buffer holds 0x200→0x11, 0x204→0x22, 0x200→0x33 with ack low.
  - fwd_addr 0x202 → fwd_hit = 1, fwd_data = 0x33.
  - fwd_addr 0x208 → fwd_hit = 0, fwd_data = 0.
  - After one ack, 0x200 still hits with 0x33.
- Simultaneous push and pop at count = 1 in SEND: required count stays 1, mem_req stays high, and the new entry is presented the next cycle.
- Reset mid-drain: with 3 entries and mem_req high, assert reset together with mem_ack. Required: next cycle mem_req = 0, wb_count = 0, in_ready = 1, fwd_hit = 0 for all prior addresses.

Source files
------------

// File: rtl/store_write_buffer_if.sv
// Bus bundle for the post-commit store buffer: store-queue push side,
// data-memory write side, load forwarding probe and occupancy status.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

interface store_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `ADDR_LEN,
  parameter int DATA_W = `DATA_LEN
);
  logic                       in_valid;
  logic                       in_ready;
  logic [ADDR_W-1:0]          in_addr;
  logic [DATA_W-1:0]          in_data;
  logic                       mem_req;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic                       mem_ack;
  logic [ADDR_W-1:0]          fwd_addr;
  logic                       fwd_hit;
  logic [DATA_W-1:0]          fwd_data;
  logic                       wb_empty;
  logic [$clog2(DEPTH):0]     wb_count;

  // Environment side: store queue, data memory and load unit.
  modport master (
    output in_valid, in_addr, in_data, mem_ack, fwd_addr,
    input  in_ready, mem_req, mem_addr, mem_wdata, fwd_hit, fwd_data,
           wb_empty, wb_count
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_addr, in_data, mem_ack, fwd_addr,
    output in_ready, mem_req, mem_addr, mem_wdata, fwd_hit, fwd_data,
           wb_empty, wb_count
  );
endinterface

// File: rtl/store_write_buffer.sv
// Post-commit store buffer: holds committed stores in program order, drains
// them to data memory one at a time over req/ack, and forwards the youngest
// matching word to probing loads.
`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `ADDR_LEN,
  parameter int DATA_W = `DATA_LEN
) (
  input logic                clk,
  input logic                reset,
  store_write_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [ADDR_W-1:0] addr_reg [DEPTH];
  logic [DATA_W-1:0] data_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  match;
  logic [PTR_W-1:0]  head_reg;
  logic [PTR_W-1:0]  tail_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [PTR_W-1:0]  fwd_idx;
  logic              full;
  logic              push;
  logic              pop;
  logic              fwd_hit_c;
  logic [DATA_W-1:0] fwd_data_c;

  // Acceptance uses registered count only, so a full buffer refuses even on a popping cycle.
  assign full = (count_reg == CNT_W'(DEPTH));
  assign push = bus.in_valid && !full;
  assign pop  = (state_reg == ST_SEND) && bus.mem_ack;

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Drain FSM: request whenever entries are held; drop back only when a pop empties the buffer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (count_reg != '0) state_next = ST_SEND;
      ST_SEND: if (pop && count_next == '0) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Pointers, occupancy and FSM state; reset abandons any in-flight write.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      state_reg <= ST_IDLE;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      count_reg <= count_next;
      state_reg <= state_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Valid bit: set on push into this slot, cleared when it is the popped head.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (push && tail_reg == PTR_W'(gi)) begin
          valid_reg[gi] <= 1'b1;
        end else if (pop && head_reg == PTR_W'(gi)) begin
          valid_reg[gi] <= 1'b0;
        end
      end

      // Payload capture; contents are qualified by the valid bit so need no reset.
      always_ff @(posedge clk) begin
        if (push && tail_reg == PTR_W'(gi)) begin
          addr_reg[gi] <= bus.in_addr;
          data_reg[gi] <= bus.in_data;
        end
      end

      // Word-granular address match against the load probe.
      assign match[gi] = valid_reg[gi] &&
                         (addr_reg[gi][ADDR_W-1:2] == bus.fwd_addr[ADDR_W-1:2]);
    end
  endgenerate

  // Forwarding: walk entries oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    fwd_idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_reg + PTR_W'(k);
      if (match[fwd_idx]) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = data_reg[fwd_idx];
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.mem_req   = (state_reg == ST_SEND);
  assign bus.mem_addr  = bus.mem_req ? addr_reg[head_reg] : '0;
  assign bus.mem_wdata = bus.mem_req ? data_reg[head_reg] : '0;
  assign bus.fwd_hit   = fwd_hit_c;
  assign bus.fwd_data  = fwd_data_c;
  assign bus.wb_empty  = (count_reg == '0);
  assign bus.wb_count  = count_reg;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: a reference model tracks
// occupancy and drain state, and a scoreboard queue holds every accepted
// store until the buffer writes it to memory.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } entry_t;

  logic clk;
  logic reset;

  store_write_buffer_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks;
  int     errors;
  int     model_count;
  bit     model_send;
  entry_t sb[$];
  bit     acc;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, update model, advance.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic [31:0] fa, output bit accepted);
    bit          do_push;
    bit          do_pop;
    int          old_count;
    entry_t      e;
    logic        exp_hit;
    logic [31:0] exp_fd;
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.mem_ack  = ack;
    bus.fwd_addr = fa;
    #1;
    check_eq("mem_req",  bus.mem_req,  model_send);
    check_eq("in_ready", bus.in_ready, model_count < DEPTH);
    check_eq("wb_count", bus.wb_count, model_count);
    check_eq("wb_empty", bus.wb_empty, model_count == 0);
    exp_hit = 1'b0;
    exp_fd  = '0;
    foreach (sb[i]) begin
      if (sb[i].a[31:2] == fa[31:2]) begin
        exp_hit = 1'b1;
        exp_fd  = sb[i].d;
      end
    end
    check_eq("fwd_hit",  bus.fwd_hit,  exp_hit);
    check_eq("fwd_data", bus.fwd_data, exp_fd);
    do_push   = v && (model_count < DEPTH);
    do_pop    = model_send && ack;
    old_count = model_count;
    if (do_pop) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        $display("write addr=%08h data=%08h", bus.mem_addr, bus.mem_wdata);
        check_eq("mem_addr",  bus.mem_addr,  e.a);
        check_eq("mem_wdata", bus.mem_wdata, e.d);
      end
    end else if (!model_send) begin
      check_eq("mem_addr_idle",  bus.mem_addr,  0);
      check_eq("mem_wdata_idle", bus.mem_wdata, 0);
    end
    if (do_push) begin
      e.a = a;
      e.d = d;
      sb.push_back(e);
    end
    model_count = old_count + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    if (!model_send) model_send = (old_count != 0);
    else if (do_pop && model_count == 0) model_send = 1'b0;
    accepted = do_push;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.mem_ack  = ack;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    sb.delete();
    model_count = 0;
    model_send  = 1'b0;
    $display("reset applied (ack=%0b)", ack);
  endtask

  task automatic drain();
    bit a2;
    for (int n = 0; n < 50 && (sb.size() != 0 || model_send); n++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, a2);
    if (sb.size() != 0 || model_send) check_eq("drain_timeout", 1, 0);
  endtask

  task automatic push_until(input logic [31:0] a, input logic [31:0] d);
    bit a2;
    a2 = 1'b0;
    for (int n = 0; n < 40 && !a2; n++)
      step(1'b1, a, d, 1'($urandom_range(0, 1)), a, a2);
    if (!a2) check_eq("push_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; model_count = 0; model_send = 1'b0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.mem_ack = 1'b0; bus.fwd_addr = '0;
    do_reset(1'b0);

    // Single store with ack tied high: count, then request, then empty.
    step(1'b1, 32'h100, 32'hAAAA_0001, 1'b1, 32'h100, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h100, acc);

    // Fill and backpressure: four accepted, fifth held until one ack.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h10 + 32'(4 * i), 32'hD000_0000 + 32'(i), 1'b0, 32'h10, acc);
    step(1'b1, 32'h20, 32'hD000_0004, 1'b0, 32'h1C, acc);
    step(1'b1, 32'h20, 32'hD000_0004, 1'b1, 32'h14, acc);
    step(1'b1, 32'h20, 32'hD000_0004, 1'b0, 32'h20, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h20, acc);
    drain();

    // Wrap-around: ten pushes interleaved with random acks.
    for (int i = 0; i < 10; i++)
      push_until(32'h1000 + 32'(8 * i), $urandom());
    drain();

    // Forwarding priority with ack low.
    step(1'b1, 32'h200, 32'h11, 1'b0, 32'h200, acc);
    step(1'b1, 32'h204, 32'h22, 1'b0, 32'h200, acc);
    step(1'b1, 32'h200, 32'h33, 1'b0, 32'h200, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h202, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h208, acc);
    step(1'b0, 32'h0, 32'h0, 1'b1, 32'h204, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h200, acc);
    drain();

    // Simultaneous push and pop at count 1 while sending.
    step(1'b1, 32'h300, 32'h3000, 1'b0, 32'h300, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h300, acc);
    step(1'b1, 32'h304, 32'h3004, 1'b1, 32'h304, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h304, acc);
    drain();

    // Reset mid-drain together with ack: everything abandoned.
    step(1'b1, 32'h400, 32'h4000, 1'b0, 32'h400, acc);
    step(1'b1, 32'h404, 32'h4004, 1'b0, 32'h400, acc);
    step(1'b1, 32'h408, 32'h4008, 1'b0, 32'h404, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h408, acc);
    do_reset(1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h400, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h404, acc);
    step(1'b0, 32'h0, 32'h0, 1'b0, 32'h408, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
